// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O controller.
// Default parameters, drop-counter width and a saturating increment.
package board_io_pkg;

  localparam int N_BTN_DEF      = 4;
  localparam int N_SW_DEF       = 2;
  localparam int N_LED_DEF      = 4;
  localparam int DEB_CYCLES_DEF = 100000;
  localparam int OREG_W_DEF     = 32;
  localparam int LED_HOLD_DEF   = 5000000;
  localparam int DROP_W         = 16;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (v == DROP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/board_io_ctrl_debounce.sv
// One input channel: 2-flop synchronizer, debounce counter, edge pulses.
// The stable level flips once the input has mismatched for DEB_CYCLES samples.
module debounce_ch
  import board_io_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // bring the raw pin into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], d_i};
  end

  // count mismatching samples; flip level and pulse on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      q_o    <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (sync[1] == q_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        q_o    <= ~q_o;
        rise_o <= ~q_o;
        fall_o <= q_o;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced buttons/switches, LED drive, capture reg.
// Define BOARD_IO_LED_STRETCH_EN to pulse-stretch LED triggers.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int N_SW       = N_SW_DEF,
  parameter int N_LED      = N_LED_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int OREG_W     = OREG_W_DEF,
  parameter int LED_HOLD   = LED_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_i,
  input  logic [N_SW-1:0]   sw_i,
  output logic [N_BTN-1:0]  btn_o,
  output logic [N_BTN-1:0]  btn_rise_o,
  output logic [N_BTN-1:0]  btn_fall_o,
  output logic [N_SW-1:0]   sw_o,
  input  logic [N_LED-1:0]  led_i,
  output logic [N_LED-1:0]  led_o,
  input  logic [OREG_W-1:0] oreg_d_i,
  input  logic              oreg_vld_i,
  input  logic              oreg_frz_i,
  output logic [OREG_W-1:0] oreg_o,
  output logic              oreg_upd_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  logic [N_SW-1:0] unused_sw_rise;
  logic [N_SW-1:0] unused_sw_fall;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .d_i    (btn_i[i]),
      .q_o    (btn_o[i]),
      .rise_o (btn_rise_o[i]),
      .fall_o (btn_fall_o[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .d_i    (sw_i[i]),
      .q_o    (sw_o[i]),
      .rise_o (unused_sw_rise[i]),
      .fall_o (unused_sw_fall[i])
    );
  end

`ifdef BOARD_IO_LED_STRETCH_EN
  localparam int LW = $clog2(LED_HOLD + 1);

  logic [N_LED-1:0] led_prev;
  logic [LW-1:0]    hold [N_LED];

  // a led_i rise (re)loads the hold count; led stays lit while it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_prev <= '0;
      led_o    <= '0;
      for (int i = 0; i < N_LED; i++) hold[i] <= '0;
    end else begin
      led_prev <= led_i;
      for (int i = 0; i < N_LED; i++) begin
        if (led_i[i] && !led_prev[i]) begin
          hold[i]  <= LW'(LED_HOLD - 1);
          led_o[i] <= 1'b1;
        end else if (hold[i] != '0) begin
          hold[i]  <= hold[i] - 1'b1;
          led_o[i] <= 1'b1;
        end else begin
          led_o[i] <= 1'b0;
        end
      end
    end
  end
`else
  localparam int unused_led_hold = LED_HOLD;

  // plain registered copy of the LED requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_o <= '0;
    else     led_o <= led_i;
  end
`endif

  // capture register; freeze wins over a capture and is counted as a drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oreg_o     <= '0;
      oreg_upd_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      oreg_upd_o <= oreg_vld_i & ~oreg_frz_i;
      if (oreg_vld_i && !oreg_frz_i) oreg_o <= oreg_d_i;
      if (oreg_vld_i && oreg_frz_i) drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

endmodule
